// File: rtl/piece_drop_if.sv
// Handshake and board bus between the game controller and the piece_drop falling stage.
// The master drives load, move and lock-ready inputs; the slave (piece_drop) drives the rest.
interface piece_drop_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] board_in;
    logic [1:0]  curr_piece;
    logic        move_left;
    logic        move_right;
    logic        drop;
    logic [31:0] board_out;
    logic        lock_valid;
    logic        lock_ready;
    logic [31:0] lock_board;
    logic        game_over;

    modport master (
        output load_valid, board_in, curr_piece, move_left, move_right, drop, lock_ready,
        input  load_ready, board_out, lock_valid, lock_board, game_over
    );

    modport slave (
        input  load_valid, board_in, curr_piece, move_left, move_right, drop, lock_ready,
        output load_ready, board_out, lock_valid, lock_board, game_over
    );
endinterface

// File: rtl/piece_drop.sv
// Falling phase of a 4x8 tetris board: spawns a piece, applies moves and gravity,
// and hands the merged board downstream once the piece lands.
module piece_drop #(
    parameter int unsigned GRAV_PERIOD = 16,
    parameter int unsigned CNT_W       = 8
) (
    input logic         clka,
    input logic         reset,
    piece_drop_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StSpawn, StFall, StLock, StOver} state_e;

    state_e           state_q;
    logic [31:0]      static_q;
    logic [31:0]      mask_q;
    logic [31:0]      board_out_q;
    logic [31:0]      lock_board_q;
    logic [1:0]       piece_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drop_q;
    logic             load_ready_q;
    logic             lock_valid_q;
    logic             game_over_q;

    logic [31:0] spawn_mask;
    logic [31:0] lat_mask;
    logic [31:0] fall_mask;
    logic        left_ok;
    logic        right_ok;
    logic        step;
    logic        landed;

    always_comb begin
        spawn_mask = 32'h0000_0002;
        unique case (piece_q)
            2'b00: spawn_mask = 32'h0000_0002;
            2'b01: spawn_mask = 32'h0000_0006;
            2'b10: spawn_mask = 32'h0000_0066;
            2'b11: spawn_mask = 32'h0000_0062;
        endcase
    end

    // Lateral move first, then gravity on the post-move mask.
    always_comb begin
        left_ok  = ((mask_q & 32'h1111_1111) == 32'h0) && (((mask_q >> 1) & static_q) == 32'h0);
        right_ok = ((mask_q & 32'h8888_8888) == 32'h0) && (((mask_q << 1) & static_q) == 32'h0);
        lat_mask = mask_q;
        if (!drop_q && bus.move_left && !bus.move_right && left_ok) begin
            lat_mask = mask_q >> 1;
        end else if (!drop_q && bus.move_right && !bus.move_left && right_ok) begin
            lat_mask = mask_q << 1;
        end
        step      = (cnt_q == CNT_W'(GRAV_PERIOD - 1)) || drop_q || bus.drop;
        landed    = (lat_mask[31:28] != 4'h0) || (((lat_mask << 4) & static_q) != 32'h0);
        fall_mask = (step && !landed) ? (lat_mask << 4) : lat_mask;
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q      <= StIdle;
            static_q     <= '0;
            mask_q       <= '0;
            board_out_q  <= '0;
            lock_board_q <= '0;
            piece_q      <= '0;
            cnt_q        <= '0;
            drop_q       <= 1'b0;
            load_ready_q <= 1'b1;
            lock_valid_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.load_valid) begin
                        static_q     <= bus.board_in;
                        piece_q      <= bus.curr_piece;
                        board_out_q  <= bus.board_in;
                        load_ready_q <= 1'b0;
                        state_q      <= StSpawn;
                    end
                end
                StSpawn: begin
                    mask_q <= spawn_mask;
                    cnt_q  <= '0;
                    drop_q <= 1'b0;
                    if ((spawn_mask & static_q) != 32'h0) begin
                        game_over_q <= 1'b1;
                        board_out_q <= static_q;
                        state_q     <= StOver;
                    end else begin
                        board_out_q <= static_q | spawn_mask;
                        state_q     <= StFall;
                    end
                end
                StFall: begin
                    mask_q      <= fall_mask;
                    board_out_q <= static_q | fall_mask;
                    cnt_q       <= step ? '0 : cnt_q + CNT_W'(1);
                    if (step && landed) begin
                        lock_board_q <= static_q | lat_mask;
                        lock_valid_q <= 1'b1;
                        drop_q       <= 1'b0;
                        state_q      <= StLock;
                    end else if (bus.drop) begin
                        drop_q <= 1'b1;
                    end
                end
                StLock: begin
                    if (bus.lock_ready) begin
                        lock_valid_q <= 1'b0;
                        load_ready_q <= 1'b1;
                        board_out_q  <= static_q;
                        mask_q       <= '0;
                        state_q      <= StIdle;
                    end
                end
                StOver: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.board_out  = board_out_q;
    assign bus.lock_valid = lock_valid_q;
    assign bus.lock_board = lock_board_q;
    assign bus.game_over  = game_over_q;
endmodule
